// File: rtl/fx_pkg.sv
// Shared definitions for the stream feature extractor: FSM states, green
// thresholds and frame-geometry defaults.
package fx_pkg;

  // Frame-geometry defaults shared by every block that walks the image.
  localparam int DEF_HEIGHT = 64;
  localparam int DEF_LENGTH = 64;
  localparam int DEF_CNT_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } fx_state_e;

  typedef logic [2:0][7:0] hsv_t;  // [2]=hue, [1]=saturation, [0]=value

  localparam hsv_t GREEN_LO = {8'd36, 8'd25, 8'd25};
  localparam hsv_t GREEN_HI = {8'd86, 8'd255, 8'd255};

  localparam int STRIP_COL = DEF_LENGTH / 2;

  // Strip column for a non-default frame width.
  function automatic int strip_col(input int length);
    return length / 2;
  endfunction

endpackage

// File: rtl/green_pixel_test.sv
// Combinational inclusive range test of an HSV pixel against lo/hi bounds;
// shared with the downstream classifier.
module green_pixel_test
  import fx_pkg::*;
(
  input  hsv_t pix,
  input  hsv_t lo,
  input  hsv_t hi,
  output logic is_green
);

  // NOTE: the output gets a default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    is_green = 1'b1;
    for (int ch = 0; ch < 3; ch++) begin
      if (pix[ch] < lo[ch] || pix[ch] > hi[ch]) is_green = 1'b0;
    end
  end

endmodule

// File: rtl/stream_feature_extract.sv
// Streams one HSV frame in raster order and counts green pixels overall, in
// the left half, and mask changes down the centre column.
module stream_feature_extract
  import fx_pkg::*;
#(
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int LENGTH = DEF_LENGTH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  hsv_t             pix_hsv,
  output logic [CNT_W-1:0] green_sum,
  output logic [CNT_W-1:0] green_left,
  output logic [CNT_W-1:0] strip_trans,
  output logic             done,
  output logic             busy
);

  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int COL_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;

  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(LENGTH - 1);
  localparam logic [COL_W-1:0] COL_STRIP = COL_W'(strip_col(LENGTH));
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Counters must hold a full frame of hits without wrapping.
  if (CNT_W < $clog2(HEIGHT * LENGTH + 1)) begin : g_cnt_w_check
    $error("stream_feature_extract: CNT_W too narrow for HEIGHT*LENGTH");
  end

  fx_state_e        state;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             prev_strip;
  logic             is_green;
  logic             accept;
  logic             last_pix;

  green_pixel_test u_green (
    .pix      (pix_hsv),
    .lo       (GREEN_LO),
    .hi       (GREEN_HI),
    .is_green (is_green)
  );

  // Status outputs decode straight from the state, so reset clears them at once.
  assign busy      = (state == ST_STREAM);
  assign pix_ready = busy;
  assign done      = (state == ST_DONE);

  assign accept   = pix_valid & pix_ready;
  assign last_pix = (row == ROW_LAST) && (col == COL_LAST);

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      row         <= '0;
      col         <= '0;
      green_sum   <= '0;
      green_left  <= '0;
      strip_trans <= '0;
      prev_strip  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Counts from the previous frame stay visible until the next start.
          if (start) begin
            state       <= ST_STREAM;
            row         <= '0;
            col         <= '0;
            green_sum   <= '0;
            green_left  <= '0;
            strip_trans <= '0;
            prev_strip  <= 1'b0;
          end
        end
        ST_STREAM: begin
          if (accept) begin
            if (col == COL_LAST) begin
              col <= '0;
              row <= row + ROW_W'(1);
            end else begin
              col <= col + COL_W'(1);
            end
            if (is_green) begin
              green_sum <= green_sum + CNT_ONE;
              if (col < COL_STRIP) green_left <= green_left + CNT_ONE;
            end
            // Row 0 only seeds the strip history; later rows count changes.
            if (col == COL_STRIP) begin
              if (row != '0 && is_green != prev_strip)
                strip_trans <= strip_trans + CNT_ONE;
              prev_strip <= is_green;
            end
            if (last_pix) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_feature_extract.sv
// Self-checking bench for stream_feature_extract on an 8x8 frame, with a
// frame-level reference model computed directly from pixel positions.
module tb_stream_feature_extract;
  import fx_pkg::*;

  localparam int H  = 8;
  localparam int L  = 8;
  localparam int N  = H * L;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  hsv_t          pix_hsv = '0;
  logic [CW-1:0] green_sum, green_left, strip_trans;
  logic          done, busy;

  stream_feature_extract #(.HEIGHT(H), .LENGTH(L), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_hsv     (pix_hsv),
    .green_sum   (green_sum),
    .green_left  (green_left),
    .strip_trans (strip_trans),
    .done        (done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_count = 0;

  always @(negedge clk) if (done === 1'b1) done_count++;

  hsv_t frame [N];
  int   exp_sum, exp_left, exp_trans;

  typedef struct {
    hsv_t pix;
    bit   green;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit ref_green(input hsv_t p);
    return (p[2] >= 36) && (p[2] <= 86) && (p[1] >= 25) && (p[0] >= 25);
  endfunction

  // Frame-level reference: counts straight from the pixel grid.
  task automatic model();
    exp_sum = 0; exp_left = 0; exp_trans = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < L; c++) begin
        if (ref_green(frame[r*L + c])) begin
          exp_sum++;
          if (c < L/2) exp_left++;
        end
      end
      if (r > 0 && ref_green(frame[r*L + L/2]) != ref_green(frame[(r-1)*L + L/2]))
        exp_trans++;
    end
  endtask

  // Caller is positioned just after a rising edge with the DUT in IDLE.
  task automatic send_frame(input bit gaps, input bit poke_start, input string tag);
    int i;
    int cycles;
    int d0;
    bit fired;
    model();
    d0 = done_count;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    i = 0;
    cycles = 0;
    while (i < N && cycles < 2000) begin
      start = 1'b0;
      if (gaps && $urandom_range(0, 2) == 0) begin
        pix_valid = 1'b0;
        pix_hsv   = hsv_t'($urandom);
      end else begin
        pix_valid = 1'b1;
        pix_hsv   = frame[i];
      end
      if (poke_start && i == 10) start = 1'b1;
      fired = pix_valid && pix_ready;
      @(posedge clk); #1;
      if (fired) i++;
      cycles++;
    end
    pix_valid = 1'b0;
    start     = 1'b0;
    check({tag, " handshakes"}, i, N);
    check({tag, " done_latency"}, {31'd0, done}, 1);
    check({tag, " early_done"}, done_count, d0);
    check({tag, " green_sum"}, green_sum, exp_sum);
    check({tag, " green_left"}, green_left, exp_left);
    check({tag, " strip_trans"}, strip_trans, exp_trans);
    @(posedge clk); #1;
    check({tag, " done_pulse_width"}, {31'd0, done}, 0);
    check({tag, " done_count"}, done_count, d0 + 1);
    repeat (3) @(posedge clk);
    #1;
    check({tag, " hold_sum"}, green_sum, exp_sum);
    check({tag, " idle_ready"}, {31'd0, pix_ready}, 0);
  endtask

  vec_t vecs [7];
  hsv_t black = {8'd0, 8'd0, 8'd0};
  hsv_t green = {8'd60, 8'd100, 8'd100};

  initial begin
    vecs[0] = '{pix: {8'd36, 8'd25, 8'd25},   green: 1'b1};
    vecs[1] = '{pix: {8'd86, 8'd255, 8'd255}, green: 1'b1};
    vecs[2] = '{pix: {8'd35, 8'd25, 8'd25},   green: 1'b0};
    vecs[3] = '{pix: {8'd87, 8'd25, 8'd25},   green: 1'b0};
    vecs[4] = '{pix: {8'd60, 8'd24, 8'd100},  green: 1'b0};
    vecs[5] = '{pix: {8'd60, 8'd100, 8'd24},  green: 1'b0};
    vecs[6] = '{pix: {8'd60, 8'd100, 8'd100}, green: 1'b1};

    #12;
    check("reset busy", {31'd0, busy}, 0);
    check("reset pix_ready", {31'd0, pix_ready}, 0);
    check("reset done", {31'd0, done}, 0);
    check("reset green_sum", green_sum, 0);
    check("reset strip_trans", strip_trans, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Uniform frames of each threshold vector.
    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < N; k++) frame[k] = vecs[v].pix;
      send_frame(1'b0, 1'b0, $sformatf("vec%0d", v));
      check($sformatf("vec%0d table_sum", v), green_sum, vecs[v].green ? N : 0);
    end

    // All-green frame.
    for (int k = 0; k < N; k++) frame[k] = green;
    send_frame(1'b0, 1'b0, "all_green");
    check("all_green left_half", green_left, N/2);

    // Centre column alternating green/black by row.
    for (int k = 0; k < N; k++)
      frame[k] = ((k % L) == L/2 && ((k / L) % 2) == 0) ? green : black;
    send_frame(1'b0, 1'b0, "strip_alt");
    check("strip_alt trans7", strip_trans, 7);
    send_frame(1'b1, 1'b0, "strip_alt_gaps");

    // Random frames, gap-free and with gaps plus junk data.
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < N; k++)
        frame[k] = {8'($urandom_range(30, 92)), 8'($urandom_range(15, 255)),
                    8'($urandom_range(15, 255))};
      send_frame(1'b0, 1'b0, $sformatf("rand%0d", t));
      send_frame(1'b1, 1'b0, $sformatf("rand%0d_gaps", t));
    end

    // start pulsed mid-stream must be ignored.
    send_frame(1'b1, 1'b1, "start_poke");

    // Reset mid-frame abandons the frame.
    for (int k = 0; k < N; k++) frame[k] = green;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pix_valid = 1'b1;
    pix_hsv = green;
    repeat (20) @(posedge clk);
    #1;
    check("mid_frame partial_sum", green_sum, 20);
    rst_n = 1'b0;
    #1;
    check("async_rst busy", {31'd0, busy}, 0);
    check("async_rst pix_ready", {31'd0, pix_ready}, 0);
    check("async_rst green_sum", green_sum, 0);
    check("async_rst green_left", green_left, 0);
    pix_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    begin
      int d0;
      d0 = done_count;
      repeat (6) @(posedge clk);
      #1;
      check("post_reset no_done", done_count, d0);
    end
    for (int k = 0; k < N; k++) frame[k] = black;
    send_frame(1'b0, 1'b0, "post_reset_black");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_feature_extract.md
STREAM_FEATURE_EXTRACT -- requirements
Module: stream_feature_extract

Interface
REQ-001 Parameter HEIGHT, default 64, image rows; SHALL be taken from global_params.vh.
REQ-002 Parameter LENGTH, default 64, image columns; SHALL be taken from global_params.vh.
REQ-003 Parameter CNT_W, default 32, width of all count outputs.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
REQ-007 pix_valid  in  1  pixel present on pix_hsv.
REQ-008 pix_ready  out  1  block accepts the pixel this cycle.
REQ-009 pix_hsv  in  [2:0][7:0]  pixel; [2]=hue, [1]=saturation, [0]=value.
REQ-010 green_sum  out  CNT_W  count of green pixels in the frame.
REQ-011 green_left  out  CNT_W  count of green pixels with column < LENGTH/2.
REQ-012 strip_trans  out  CNT_W  count of mask changes down column LENGTH/2.
REQ-013 done  out  1  one-cycle pulse; all three counts are valid and held from this cycle.
REQ-014 busy  out  1  high in STREAM.

Function
REQ-015 The FSM SHALL have three states: IDLE, STREAM, DONE.
REQ-016 IDLE->STREAM on start. Entry SHALL clear row, column, both sums, the transition count and the previous-strip-bit register.
REQ-017 pix_ready SHALL be 1 in STREAM and 0 in IDLE and DONE.
REQ-018 A pixel is accepted only in a cycle with pix_valid & pix_ready; data present without a handshake SHALL be ignored.
REQ-019 Green test SHALL be inclusive on all channels: 36<=H<=86, 25<=S<=255, 25<=V<=255.
REQ-020 Pixels arrive in raster order. On each accepted pixel:
  - column increments;
  - at column LENGTH-1 the column wraps to 0 and the row increments.
REQ-021 Each accepted green pixel SHALL increment green_sum; it also increments green_left if its column < LENGTH/2.
REQ-022 For an accepted pixel at column LENGTH/2:
  - in rows > 0, strip_trans increments when the mask bit differs from the stored previous-strip bit;
  - in all rows, the mask bit is stored as the previous-strip bit.
REQ-023 Acceptance of pixel (HEIGHT-1, LENGTH-1) SHALL move the FSM to DONE in the next cycle; the counts SHALL include that pixel.
REQ-024 DONE lasts exactly one cycle, asserts done, then returns to IDLE.
REQ-025 Counts SHALL hold their values in IDLE until the next start.
REQ-026 start asserted in STREAM or DONE SHALL be ignored.
REQ-027 Latency: done SHALL assert 1 cycle after the last pixel handshake.
REQ-028 Counters SHALL be unsigned and SHALL NOT wrap; CNT_W >= clog2(HEIGHT*LENGTH+1) SHALL hold, checked by an elaboration assertion.

Reset
REQ-029 While rst_n=0, the following SHALL be forced to 0 immediately, independent of clk: state (IDLE), row, column, green_sum, green_left, strip_trans, previous-strip bit, done, busy and pix_ready.
REQ-030 Reset asserted mid-frame SHALL abandon the frame; no done pulse follows deassertion.

Structure
REQ-031 Package fx_pkg SHALL hold:
  - the FSM state enum;
  - GREEN_LO = {36,25,25} and GREEN_HI = {86,255,255};
  - STRIP_COL = LENGTH/2.
REQ-032 Sub-module green_pixel_test SHALL hold the purely combinational threshold compare (pixel, lo, hi -> bit); it is reused by the downstream classifier.
REQ-033 Downstream classification SHALL be: strip_trans==4 -> scissors (2); else green_left>1200 -> paper (1); else rock (0). This block SHALL NOT implement it.

Verification (HEIGHT=LENGTH=8 unless stated)
REQ-034 All-green frame {60,100,100}, pix_valid held high -> done 1 cycle after the 64th handshake; green_sum=64, green_left=32, strip_trans=0.
REQ-035 Column 4 alternating green/black by row, rest black -> green_sum=4, green_left=0, strip_trans=7.
REQ-036 Boundary pixels {36,25,25} and {86,255,255} counted; {35,25,25} and {87,25,25} not counted; {60,24,100} not counted.
REQ-037 Random pix_valid gaps, plus pix_hsv changing while pix_valid=0 -> counts identical to the gap-free run.
REQ-038 rst_n pulled low after 20 pixels, then start and a full black frame -> no done before the new frame completes; all counts 0.
REQ-039 start pulsed during STREAM -> no restart; counts match the uninterrupted frame.
